fpu_param: RTL

Parametrised, handshaked floating-point unit for the tinyZuse datapath. It supports add, subtract and multiply on sign/exponent/mantissa operands of configurable width. It replaces the fixed 7/15-bit add/sub unit. New capabilities:
- ready/valid flow control
- iterative shift-add multiply
- exact-zero input handling
- overflow/underflow flags

It sits between the register file and the result write-back stage.

---
 rtl/fpu_pkg.sv | 33 +++
 rtl/fpu_norm.sv | 41 ++++
 rtl/fpu_param.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================
// fpu_pkg : op codes, FSM states and zero-encoding constants
// rev 1.0
// ============================================================
package fpu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ALIGN  = 3'd1,
      S_ADDSUB = 3'd2,
      S_MUL    = 3'd3,
      S_NORM   = 3'd4,
      S_PACK   = 3'd5,
      S_HOLD   = 3'd6
   } state_t;

   // Zero is the most negative exponent paired with a lone leading one.
   function automatic logic [31:0] zero_exp(input int ew);
      return 32'd1 << (ew - 1);
   endfunction

   function automatic logic [31:0] zero_man(input int mw);
      return 32'd1 << (mw - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_norm.sv
`default_nettype none
// ============================================================
// fpu_norm : one-cycle leading-one detect and normalising shift
// rev 1.0
// ============================================================
module fpu_norm #(
   parameter int MW = 15,
   parameter int EW = 7
) (
   input  logic [MW+1:0] i_mag,
   input  logic [EW+1:0] i_exp,
   output logic [MW-1:0] o_m,
   output logic [EW+1:0] o_e,
   output logic          o_zero
);

   localparam int LZW = $clog2(MW + 1);

   logic [LZW-1:0] w_lz;

   // Highest set bit wins because the loop runs upward.
   always_comb begin
      w_lz = '0;
      for (int i = 0; i < MW; i++) begin
         if (i_mag[i]) w_lz = LZW'(MW - 1 - i);
      end
   end

   always_comb begin
      o_zero = (i_mag == '0);
      if (|i_mag[MW+1:MW]) begin
         o_m = i_mag[MW:1];
         o_e = i_exp + (EW+2)'(1);
      end else begin
         o_m = i_mag[MW-1:0] << w_lz;
         o_e = i_exp - (EW+2)'(w_lz);
      end
   end

endmodule
`default_nettype wire

// File: rtl/fpu_param.sv
`default_nettype none
// ============================================================
// fpu_param : ready/valid add/sub/mul FPU, truncating results
// rev 1.0
// ============================================================
module fpu_param
   import fpu_pkg::*;
#(
   parameter int EW = 7,
   parameter int MW = 15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    op,
   input  logic          a_s,
   input  logic [EW-1:0] a_e,
   input  logic [MW-1:0] a_m,
   input  logic          b_s,
   input  logic [EW-1:0] b_e,
   input  logic [MW-1:0] b_m,
   output logic          res_s,
   output logic [EW-1:0] res_e,
   output logic [MW-1:0] res_m,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          flg_ovf,
   output logic          flg_unf,
   output logic          flg_zero,
   output logic          flg_inv
);

   localparam int CW = $clog2(MW + 1);
   localparam logic [EW-1:0]        c_zero_e = EW'(zero_exp(EW));
   localparam logic [MW-1:0]        c_zero_m = MW'(zero_man(MW));
   localparam logic signed [EW+1:0] c_emax   = (EW+2)'(2**(EW-1) - 1);
   localparam logic signed [EW+1:0] c_emin   = (EW+2)'(-(2**(EW-1)));

   state_t          r_state, w_next;
   logic [1:0]      r_op;
   logic            r_as, r_bs, r_sbig, r_ssmall, r_sign;
   logic [EW-1:0]   r_ae, r_be;
   logic [MW-1:0]   r_am, r_bm;
   logic [MW+1:0]   r_big, r_small, r_mag;
   logic [EW+1:0]   r_exp;
   logic [MW-1:0]   r_acc, r_mplr, r_mcand;
   logic [CW-1:0]   r_cnt;
   logic [MW-1:0]   r_nm;
   logic [EW+1:0]   r_ne;
   logic            r_nz;

   logic            w_az, w_bz, w_bs_eff, w_a_ge, w_nz;
   logic [EW+1:0]   w_ae_x, w_be_x, w_diff, w_dabs, w_ne;
   logic [MW+1:0]   w_small, w_nin;
   logic [MW:0]     w_msum;
   logic [MW-1:0]   w_nm;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (in_valid) w_next = (op == OP_MUL) ? S_MUL : S_ALIGN;
         S_ALIGN:  w_next = S_ADDSUB;
         S_ADDSUB: w_next = S_NORM;
         S_MUL:    if (r_cnt == CW'(MW - 1)) w_next = S_NORM;
         S_NORM:   w_next = S_PACK;
         S_PACK:   w_next = S_HOLD;
         S_HOLD:   if (out_ready) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == S_IDLE);
      out_valid = (r_state == S_HOLD);
   end

   // A zero operand borrows the other's exponent and sign, contributing nothing.
   assign w_az     = (a_e == c_zero_e);
   assign w_bz     = (b_e == c_zero_e);
   assign w_bs_eff = b_s ^ (op == OP_SUB);

   assign w_ae_x  = {{2{r_ae[EW-1]}}, r_ae};
   assign w_be_x  = {{2{r_be[EW-1]}}, r_be};
   assign w_diff  = w_ae_x - w_be_x;
   assign w_a_ge  = ~w_diff[EW+1];
   assign w_dabs  = w_a_ge ? w_diff : -w_diff;
   assign w_small = (w_dabs >= (EW+2)'(MW + 2)) ? '0
                  : ({2'b00, (w_a_ge ? r_bm : r_am)} >> w_dabs);

   // {r_acc, r_mplr} forms the 2*MW product register; low bits shift into r_mplr.
   assign w_msum = {1'b0, r_acc} + (r_mplr[0] ? {1'b0, r_mcand} : '0);
   assign w_nin  = (r_op == OP_MUL) ? {1'b0, r_acc, r_mplr[MW-1]} : r_mag;

   fpu_norm #(.MW(MW), .EW(EW)) u_norm (
      .i_mag  (w_nin),
      .i_exp  (r_exp),
      .o_m    (w_nm),
      .o_e    (w_ne),
      .o_zero (w_nz)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op <= '0;  r_as <= 1'b0;  r_bs <= 1'b0;  r_ae <= '0;  r_be <= '0;
         r_am <= '0;  r_bm <= '0;  r_big <= '0;  r_small <= '0;  r_mag <= '0;
         r_sbig <= 1'b0;  r_ssmall <= 1'b0;  r_sign <= 1'b0;  r_exp <= '0;
         r_acc <= '0;  r_mplr <= '0;  r_mcand <= '0;  r_cnt <= '0;
         r_nm <= '0;  r_ne <= '0;  r_nz <= 1'b0;
         res_s <= 1'b0;  res_e <= '0;  res_m <= '0;
         flg_ovf <= 1'b0;  flg_unf <= 1'b0;  flg_zero <= 1'b0;  flg_inv <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (in_valid) begin
               r_op    <= op;
               r_as    <= w_az ? w_bs_eff : a_s;
               r_ae    <= w_az ? b_e : a_e;
               r_am    <= w_az ? '0 : a_m;
               r_bs    <= w_bz ? a_s : w_bs_eff;
               r_be    <= w_bz ? a_e : b_e;
               r_bm    <= w_bz ? '0 : b_m;
               r_sign  <= a_s ^ b_s;
               r_exp   <= {{2{a_e[EW-1]}}, a_e} + {{2{b_e[EW-1]}}, b_e};
               r_acc   <= '0;
               r_mplr  <= b_m;
               r_mcand <= (w_az || w_bz) ? '0 : a_m;
               r_cnt   <= '0;
            end
            S_ALIGN: begin
               r_big    <= {2'b00, (w_a_ge ? r_am : r_bm)};
               r_small  <= w_small;
               r_sbig   <= w_a_ge ? r_as : r_bs;
               r_ssmall <= w_a_ge ? r_bs : r_as;
               r_exp    <= w_a_ge ? w_ae_x : w_be_x;
            end
            S_ADDSUB: begin
               if (r_sbig == r_ssmall) begin
                  r_mag  <= r_big + r_small;
                  r_sign <= r_sbig;
               end else if (r_big >= r_small) begin
                  r_mag  <= r_big - r_small;
                  r_sign <= r_sbig;
               end else begin
                  r_mag  <= r_small - r_big;
                  r_sign <= r_ssmall;
               end
            end
            S_MUL: begin
               r_acc  <= w_msum[MW:1];
               r_mplr <= {w_msum[0], r_mplr[MW-1:1]};
               r_cnt  <= r_cnt + CW'(1);
            end
            S_NORM: begin
               r_nm <= w_nm;
               r_ne <= w_ne;
               r_nz <= w_nz;
            end
            S_PACK: begin
               flg_ovf  <= 1'b0;
               flg_unf  <= 1'b0;
               flg_zero <= 1'b0;
               flg_inv  <= 1'b0;
               res_s    <= 1'b0;
               res_e    <= c_zero_e;
               res_m    <= c_zero_m;
               if (r_op == OP_RSV) begin
                  flg_inv <= 1'b1;
               end else if (r_nz) begin
                  flg_zero <= 1'b1;
               end else if ($signed(r_ne) > c_emax) begin
                  res_s   <= r_sign;
                  res_e   <= c_emax[EW-1:0];
                  res_m   <= '1;
                  flg_ovf <= 1'b1;
               end else if ($signed(r_ne) <= c_emin) begin
                  flg_unf  <= 1'b1;
                  flg_zero <= 1'b1;
               end else begin
                  res_s <= r_sign;
                  res_e <= r_ne[EW-1:0];
                  res_m <= r_nm;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
